// File: rtl/uflash_loader_pkg.sv
// Shared constants, state encoding and bounds helper for the user-flash loader.
package uflash_pkg;
  localparam int FLASH_ROWS  = 304;
  localparam int FLASH_COLS  = 64;
  localparam int FLASH_WORDS = FLASH_ROWS * FLASH_COLS;

  localparam logic [3:0] WSTRB_READ  = 4'b0000;
  localparam logic [3:0] WSTRB_WORD  = 4'b1111;
  localparam logic [3:0] WSTRB_ERASE = 4'b0001;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_RD, S_WR, S_FIN} state_e;

  // 17 bits hold the largest possible src+len without overflow.
  function automatic logic out_of_bounds(input logic [14:0] src, input logic [15:0] len,
                                         input int words);
    logic [16:0] last;
    last = {2'b00, src} + {1'b0, len};
    return last > 17'(words);
  endfunction
endpackage

// File: rtl/uflash_loader_if.sv
// sel/wstrb/addr/ready word bus, shared by the flash read port and RAM write port.
interface uflash_loader_if #(parameter int AW = 15);
  logic          sel;
  logic [3:0]    wstrb;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          ready;

  modport master (output sel, wstrb, addr, wdata, input rdata, ready);
  modport slave  (input sel, wstrb, addr, wdata, output rdata, ready);
endinterface

// File: rtl/uflash_loader_bus_timeout.sv
// Per-transaction wait counter; expired flags the TIMEOUT-th cycle without ready.
module bus_timeout #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                 cnt_d = '0;
    else if (en && !expired) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
endmodule

// File: rtl/uflash_loader.sv
// Copies len words from user flash into RAM, one read then one write per word,
// accumulating a checksum and flagging bounds or bus-timeout errors.
module uflash_loader #(
  parameter int RAM_AW      = 13,
  parameter int TIMEOUT     = 1024,
  parameter int FLASH_WORDS = uflash_pkg::FLASH_WORDS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [14:0]       src_addr,
  input  logic [RAM_AW-1:0] dst_addr,
  input  logic [15:0]       len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       checksum,
  uflash_loader_if.master   fl,
  uflash_loader_if.master   ram
);
  import uflash_pkg::*;

  state_e            state_q, state_d;
  logic [14:0]       src_q, src_d;
  logic [RAM_AW-1:0] dst_q, dst_d;
  logic [15:0]       rem_q, rem_d;
  logic [31:0]       wdata_q, wdata_d, sum_q, sum_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic              fl_sel_q, fl_sel_d, ram_sel_q, ram_sel_d;
  logic              tmo;

  bus_timeout #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (state_d != state_q),
    .en      (state_q == S_RD || state_q == S_WR),
    .expired (tmo)
  );

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    wdata_d = wdata_q;
    sum_d   = sum_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_CHECK;
        err_d   = 1'b0;
        sum_d   = '0;
        src_d   = src_addr;
        dst_d   = dst_addr;
        rem_d   = len;
      end
      S_CHECK: begin
        if (rem_q == '0) state_d = S_FIN;
        else if (out_of_bounds(src_q, rem_q, FLASH_WORDS)) begin
          state_d = S_FIN;
          err_d   = 1'b1;
        end else state_d = S_RD;
      end
      S_RD: begin
        if (fl.ready) begin
          wdata_d = fl.rdata;
          sum_d   = sum_q + fl.rdata;
          state_d = S_WR;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end
      end
      S_WR: begin
        if (ram.ready) begin
          src_d   = src_q + 15'd1;
          dst_d   = dst_q + 1'b1;
          rem_d   = rem_q - 16'd1;
          state_d = (rem_q == 16'd1) ? S_FIN : S_RD;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Outputs follow the next state so they are flop-driven, not decoded.
    fl_sel_d  = (state_d == S_RD);
    ram_sel_d = (state_d == S_WR);
    done_d    = (state_d == S_FIN);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      rem_q     <= '0;
      wdata_q   <= '0;
      sum_q     <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fl_sel_q  <= 1'b0;
      ram_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      rem_q     <= rem_d;
      wdata_q   <= wdata_d;
      sum_q     <= sum_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      fl_sel_q  <= fl_sel_d;
      ram_sel_q <= ram_sel_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign checksum  = sum_q;
  assign fl.sel    = fl_sel_q;
  assign fl.wstrb  = WSTRB_READ;
  assign fl.addr   = src_q;
  assign fl.wdata  = '0;
  assign ram.sel   = ram_sel_q;
  assign ram.wstrb = ram_sel_q ? WSTRB_WORD : WSTRB_READ;
  assign ram.addr  = dst_q;
  assign ram.wdata = wdata_q;
endmodule
